// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-entry layout so decode and the fetch queue agree on {adel, pc, inst}.
package inst_fetch_queue_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = 1 + ADDR_W + INST_W;

    typedef struct packed {
        logic              adel;
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // AdEL: instruction fetch from a non-word-aligned address.
    function automatic logic isMisaligned(input logic [ADDR_W-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Register array holding the queued fetch entries: synchronous write and clear,
// asynchronous read so the head entry is visible to decode without a cycle of delay.
module inst_fq_mem
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [PTR_W-1:0]   waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]   raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode: buffers {pc, inst} pairs,
// throttles fetch so in-flight returns always fit, and tags misaligned PCs.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int SKID  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              inst_valid_i,
    output logic              pc_en_o,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_adel_o,
    input  logic              id_ready_i,
    output logic              overflow_o
);

    localparam logic [PTR_W:0]   FULL_C  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_C   = (PTR_W+1)'(1);
    localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);
    localparam logic [PTR_W+1:0] SKID_C  = (PTR_W+2)'(SKID);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     rd_entry;

    assign full = (count_q == FULL_C);
    assign pop  = id_valid_o & id_ready_i & ~flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = inst_valid_i & ~flush & (~full | pop);

    assign wr_entry.adel = isMisaligned(pc_i);
    assign wr_entry.pc   = pc_i;
    assign wr_entry.inst = inst_i;

    inst_fq_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (inst_valid_i & ~flush & full & ~pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // SKID slots are held back for fetches already issued when pc_en_o drops.
    assign pc_en_o    = ~flush & (({1'b0, count_q} + SKID_C) < DEPTH_C);
    assign id_valid_o = (count_q != '0);
    assign id_pc_o    = rd_entry.pc;
    assign id_inst_o  = rd_entry.inst;
    assign id_adel_o  = rd_entry.adel;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a scoreboard queue models the FIFO and
// every cycle the head, handshake and throttle outputs are compared against it.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int SKID  = 1;

    typedef struct packed {
        logic        adel;
        logic [31:0] pc;
        logic [31:0] inst;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        inst_valid_i;
    logic        pc_en_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_adel_o;
    logic        id_ready_i;
    logic        overflow_o;

    sbEntry_t    scoreboard[$];
    logic        modelOverflow;
    int          vectorCount;
    int          miscompareCount;

    inst_fetch_queue #(
        .DEPTH (DEPTH),
        .PTR_W (2),
        .SKID  (SKID)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .inst_valid_i (inst_valid_i),
        .pc_en_o      (pc_en_o),
        .id_valid_o   (id_valid_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_adel_o    (id_adel_o),
        .id_ready_i   (id_ready_i),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            miscompareCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic rdy, input logic fl);
        logic     modelFull;
        logic     modelPop;
        sbEntry_t entry;
        @(negedge clk);
        inst_valid_i = v;
        pc_i         = pc;
        inst_i       = inst;
        id_ready_i   = rdy;
        flush        = fl;
        #1;
        checkOutput("id_valid", {31'b0, id_valid_o}, {31'b0, scoreboard.size() != 0});
        checkOutput("pc_en", {31'b0, pc_en_o}, {31'b0, !fl && (scoreboard.size() + SKID < DEPTH)});
        checkOutput("overflow", {31'b0, overflow_o}, {31'b0, modelOverflow});
        if (scoreboard.size() != 0) begin
            checkOutput("id_pc", id_pc_o, scoreboard[0].pc);
            checkOutput("id_inst", id_inst_o, scoreboard[0].inst);
            checkOutput("id_adel", {31'b0, id_adel_o}, {31'b0, scoreboard[0].adel});
        end
        modelFull = (scoreboard.size() == DEPTH);
        modelPop  = (scoreboard.size() != 0) && rdy && !fl;
        if (fl) begin
            scoreboard.delete();
        end else begin
            if (v && modelFull && !modelPop) modelOverflow = 1'b1;
            if (modelPop) void'(scoreboard.pop_front());
            if (v && (!modelFull || modelPop)) begin
                entry.adel = (pc[1:0] != 2'b00);
                entry.pc   = pc;
                entry.inst = inst;
                scoreboard.push_back(entry);
            end
        end
        @(posedge clk);
    endtask

    task automatic applyReset(input logic withFlush, input logic withPush);
        @(negedge clk);
        reset        = 1'b1;
        flush        = withFlush;
        inst_valid_i = withPush;
        pc_i         = 32'h8000_0100;
        inst_i       = 32'hDEAD_BEEF;
        id_ready_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset        = 1'b0;
        flush        = 1'b0;
        inst_valid_i = 1'b0;
        id_ready_i   = 1'b0;
        scoreboard.delete();
        modelOverflow = 1'b0;
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        modelOverflow   = 1'b0;
        reset           = 1'b0;
        flush           = 1'b0;
        pc_i            = '0;
        inst_i          = '0;
        inst_valid_i    = 1'b0;
        id_ready_i      = 1'b0;

        // Reset then idle: empty, fetch enabled, cleared storage.
        applyReset(1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_id_inst", id_inst_o, 32'h0);
        checkOutput("reset_id_pc", id_pc_o, 32'h0);

        // Single push, then stall for three cycles with the head held.
        applyStimulus(1'b1, 32'hBFC0_0000, 32'h2401_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill to full, push with pop while full, then drain in FIFO order.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h8000_0000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h8000_0010, 32'h1000_0004, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Full and push without pop: entry dropped, sticky overflow.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h9000_0000 + 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h9000_0040, 32'h2BAD_0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Three queued, flush with a push pending; overflow survives the flush.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'hA000_0000 + 32'(i * 4), 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hA000_0100, 32'h3333_3333, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h8000_0010, 32'h3C1D_8000, 1'b0, 1'b0);

        // Misaligned PC reaches the head tagged; then reset with two queued.
        applyStimulus(1'b1, 32'h8000_0002, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8000_0004, 32'h2402_0002, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyReset(1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset and flush together behave as reset alone.
        applyStimulus(1'b1, 32'hB000_0000, 32'h4000_0000, 1'b0, 1'b0);
        applyReset(1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Mixed random traffic against the scoreboard.
        for (int i = 0; i < 60; i++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
